// File: rtl/alu.sv
// Single-cycle ALU with registered result and Zero flag (one cycle latency).
// Optional Negative/Carry/Overflow flags are built when ALU_EXT_FLAGS_EN is defined.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
`ifdef ALU_EXT_FLAGS_EN
    ,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow
`endif
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    logic [4:0]       shamt;
    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d, zero_q;

    // Only the low five bits of SrcB steer the shifter.
    assign shamt = SrcB[4:0];

    always_comb begin
        result_d = '0;
        case (ALUControl)
            OP_ADD:  result_d = SrcA + SrcB;
            OP_SUB:  result_d = SrcA - SrcB;
            OP_SLL:  result_d = SrcA << shamt;
            OP_SLT:  result_d[0] = ($signed(SrcA) < $signed(SrcB));
            OP_SLTU: result_d[0] = (SrcA < SrcB);
            OP_XOR:  result_d = SrcA ^ SrcB;
            OP_SRL:  result_d = SrcA >> shamt;
            OP_SRA:  result_d = $signed(SrcA) >>> shamt;
            OP_OR:   result_d = SrcA | SrcB;
            OP_AND:  result_d = SrcA & SrcB;
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;

`ifdef ALU_EXT_FLAGS_EN
    logic [WIDTH:0] add_ext, sub_ext;
    logic           negative_d, negative_q;
    logic           carry_d, carry_q;
    logic           overflow_d, overflow_q;

    // Subtraction as A + ~B + 1, so the carry-out is the inverted borrow.
    always_comb begin
        add_ext    = {1'b0, SrcA} + {1'b0, SrcB};
        sub_ext    = {1'b0, SrcA} + {1'b0, ~SrcB} + {{WIDTH{1'b0}}, 1'b1};
        negative_d = result_d[WIDTH-1];
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        if (ALUControl == OP_ADD) begin
            carry_d    = add_ext[WIDTH];
            overflow_d = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                         (add_ext[WIDTH-1] != SrcA[WIDTH-1]);
        end else if (ALUControl == OP_SUB) begin
            carry_d    = sub_ext[WIDTH];
            overflow_d = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                         (sub_ext[WIDTH-1] != SrcA[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            negative_q <= negative_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign Negative = negative_q;
    assign Carry    = carry_q;
    assign Overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: each step drives operands, clocks once, and checks
// the registered result and Zero flag against hand-computed values.
module tb_alu;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    logic        clk;
    logic        reset;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;
`ifdef ALU_EXT_FLAGS_EN
    logic        Negative;
    logic        Carry;
    logic        Overflow;
`endif

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
`ifdef ALU_EXT_FLAGS_EN
        ,
        .Negative   (Negative),
        .Carry      (Carry),
        .Overflow   (Overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Result plus the Zero flag implied by the expected result.
    task automatic expect_res(input string tag, input logic [31:0] exp);
        check32(tag, ALUResult, exp);
        check1({tag, "_zero"}, Zero, (exp == 32'h0));
    endtask

    // Drive inputs away from the active edge, clock once, sample 1ns after.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        SrcA       = a;
        SrcB       = b;
        ALUControl = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        SrcA       = 32'd5;
        SrcB       = 32'd3;
        ALUControl = OP_ADD;

        // Reset held for two edges with a live ADD on the inputs.
        @(posedge clk); #1;
        expect_res("reset_c1", 32'h0);
        @(posedge clk); #1;
        expect_res("reset_c2", 32'h0);
`ifdef ALU_EXT_FLAGS_EN
        check1("reset_neg", Negative, 1'b0);
        check1("reset_carry", Carry, 1'b0);
        check1("reset_ovf", Overflow, 1'b0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Arithmetic
        step(32'd50, 32'd25, OP_ADD);               expect_res("add_50_25", 32'h4B);
        step(32'hFFFF_FFFF, 32'd1, OP_ADD);         expect_res("add_wrap", 32'h0);
        step(32'd100, 32'd30, OP_SUB);              expect_res("sub_100_30", 32'h46);
        step(32'd10, 32'd10, OP_SUB);               expect_res("sub_10_10", 32'h0);
        step(32'd3, 32'd5, OP_SUB);                 expect_res("sub_neg", 32'hFFFF_FFFE);

        // Logic
        step(32'hF0F0_F0F0, 32'h0F0F_0F0F, OP_AND); expect_res("and", 32'h0);
        step(32'hF0F0_F0F0, 32'h0F0F_0F0F, OP_OR);  expect_res("or", 32'hFFFF_FFFF);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_XOR); expect_res("xor_same", 32'h0);
        step(32'h1234_5678, 32'hFF00_FF00, OP_XOR); expect_res("xor_mix", 32'hED34_A978);

        // Shifts
        step(32'h1, 32'd4, OP_SLL);                 expect_res("sll_4", 32'h10);
        step(32'h8000_0000, 32'd1, OP_SRL);         expect_res("srl_1", 32'h4000_0000);
        step(32'h8000_0000, 32'd1, OP_SRA);         expect_res("sra_1", 32'hC000_0000);
        step(32'h1, 32'h24, OP_SLL);                expect_res("sll_upper_ign", 32'h10);
        step(32'h8000_0000, 32'd31, OP_SRL);        expect_res("srl_31", 32'h1);
        step(32'h4000_0000, 32'd30, OP_SRA);        expect_res("sra_pos", 32'h1);

        // Compare and unused codes
        step(32'hFFFF_FFFF, 32'd1, OP_SLT);         expect_res("slt_neg", 32'h1);
        step(32'hFFFF_FFFF, 32'd1, OP_SLTU);        expect_res("sltu", 32'h0);
        step(32'd1, 32'hFFFF_FFFF, OP_SLT);         expect_res("slt_pos", 32'h0);
        step(32'd1, 32'hFFFF_FFFF, OP_SLTU);        expect_res("sltu_lt", 32'h1);
        step(32'h1234_5678, 32'h1, 4'b1111);        expect_res("illegal_f", 32'h0);
        step(32'h1234_5678, 32'h1, 4'b1001);        expect_res("illegal_9", 32'h0);

        // Back-to-back: before each edge the output must still hold the previous result.
        step(32'd3, 32'd4, OP_ADD);                 expect_res("b2b_add", 32'h7);
        @(negedge clk);
        SrcA = 32'd3; SrcB = 32'd4; ALUControl = OP_SUB;
        check32("b2b_hold1", ALUResult, 32'h7);
        @(posedge clk); #1;
        expect_res("b2b_sub", 32'hFFFF_FFFF);
        @(negedge clk);
        SrcA = 32'hA5; SrcB = 32'h0F; ALUControl = OP_XOR;
        check32("b2b_hold2", ALUResult, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        expect_res("b2b_xor", 32'hAA);
        @(negedge clk);
        SrcA = 32'hF000_0000; SrcB = 32'd4; ALUControl = OP_SRA;
        check32("b2b_hold3", ALUResult, 32'hAA);
        @(posedge clk); #1;
        expect_res("b2b_sra", 32'hFF00_0000);
        @(negedge clk);
        SrcA = 32'd3; SrcB = 32'd4; ALUControl = OP_SLTU;
        check32("b2b_hold4", ALUResult, 32'hFF00_0000);
        @(posedge clk); #1;
        expect_res("b2b_sltu", 32'h1);

        // Reset in mid-stream discards that cycle's operation.
        @(negedge clk);
        SrcA = 32'd1; SrcB = 32'd2; ALUControl = OP_ADD;
        reset = 1'b1;
        @(posedge clk); #1;
        expect_res("mid_reset", 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        expect_res("post_reset", 32'h3);

`ifdef ALU_EXT_FLAGS_EN
        step(32'h7FFF_FFFF, 32'd1, OP_ADD);
        expect_res("flag_add_res", 32'h8000_0000);
        check1("flag_add_ovf", Overflow, 1'b1);
        check1("flag_add_neg", Negative, 1'b1);
        check1("flag_add_carry", Carry, 1'b0);
        step(32'hFFFF_FFFF, 32'd1, OP_ADD);
        check1("flag_wrap_carry", Carry, 1'b1);
        check1("flag_wrap_ovf", Overflow, 1'b0);
        step(32'd10, 32'd10, OP_SUB);
        check1("flag_sub_carry", Carry, 1'b1);
        step(32'd3, 32'd5, OP_SUB);
        check1("flag_sub_borrow", Carry, 1'b0);
        check1("flag_sub_neg", Negative, 1'b1);
        step(32'h8000_0000, 32'd1, OP_SUB);
        check1("flag_sub_ovf", Overflow, 1'b1);
        step(32'h8000_0000, 32'd1, OP_SRA);
        check1("flag_sra_neg", Negative, 1'b1);
        check1("flag_sra_carry", Carry, 1'b0);
        check1("flag_sra_ovf", Overflow, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
